code_player: RTL

Transmitter side of the four-button combination-lock interface. It replays a stored digit sequence as timed press/release activity on four active-high switch lines, so the lock can be exercised in hardware and in simulation without a human at the buttons. It sits between a trigger source (pushbutton or test harness) and the lock's SW1–SW4 inputs. The lock counts a digit on each 1→0 transition of a line.

---
 rtl/code_pkg.sv | 26 ++
 rtl/code_player_phase_timer.sv | 26 ++
 rtl/code_player.sv | 132 +++++++++++++
 3 files changed

// File: rtl/code_pkg.sv
// Shared types and constants for the combination-lock code player.
package code_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [1:0] SW1_D = 2'd0;
  localparam logic [1:0] SW2_D = 2'd1;
  localparam logic [1:0] SW3_D = 2'd2;
  localparam logic [1:0] SW4_D = 2'd3;

  // SW1,SW1,SW2,SW3,SW4 with digit 0 in the low bits.
  localparam logic [9:0] DEFAULT_CODE = 10'h390;

  function automatic logic [3:0] digit_onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/code_player_phase_timer.sv
// Loadable down-counter that times both the press and gap phases.
module phase_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/code_player.sv
// Replays a stored digit sequence as timed one-hot press/release activity
// on the four lock switch lines.
module code_player
  import code_pkg::*;
#(
  parameter int unsigned CODE_LEN     = 5,
  parameter int unsigned PRESS_CYCLES = 12_000_000,
  parameter int unsigned GAP_CYCLES   = 12_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*CODE_LEN-1:0] code,
  output logic [3:0]            sw,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned TW = $clog2(max_u(PRESS_CYCLES, GAP_CYCLES) + 1);
  localparam int unsigned IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  localparam logic [TW-1:0] PRESS_LD = TW'(PRESS_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(CODE_LEN - 1);

  state_e                state_q;
  logic [2*CODE_LEN-1:0] shift_q;
  logic [2*CODE_LEN-1:0] shift_d;
  logic [IW-1:0]         idx_q;
  logic [3:0]            sw_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  tmr_load;
  logic [TW-1:0]         tmr_value;
  logic                  tmr_zero;

  phase_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  assign shift_d = shift_q >> 2;

  // Timer reloads happen on the same edges as the FSM phase changes.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tmr_load  = 1'b1;
          tmr_value = PRESS_LD;
        end
      end
      PRESS: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = GAP_LD;
        end
      end
      GAP: begin
        if (tmr_zero && (idx_q != LAST_IDX)) begin
          tmr_load  = 1'b1;
          tmr_value = PRESS_LD;
        end
      end
      default: begin
        tmr_load  = 1'b0;
        tmr_value = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      sw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            shift_q <= code;
            idx_q   <= '0;
            sw_q    <= digit_onehot(code[1:0]);
            busy_q  <= 1'b1;
            state_q <= PRESS;
          end
        end
        PRESS: begin
          if (tmr_zero) begin
            sw_q    <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (tmr_zero) begin
            if (idx_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              // Decode from the advanced register so sw lines up with the new digit.
              idx_q   <= idx_q + 1'b1;
              shift_q <= shift_d;
              sw_q    <= digit_onehot(shift_d[1:0]);
              state_q <= PRESS;
            end
          end
        end
        default: begin
          sw_q    <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sw   = sw_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
